// File: rtl/eth_payload_reader.sv
// Streams 16-bit sample words from a FIFO to a UDP/IP core as bytes, high byte first.
// Define ETH_PAYLOAD_SEQ_HDR_EN to prefix each datagram with a 2-byte sequence number.
`timescale 1ns/1ps
module eth_payload_reader #(
  parameter logic [15:0] HDR_SEQ_INIT = 16'd0
) (
  input  logic        clk125M,
  input  logic        udp_gmii_rst_n,
  input  logic        tx_en_pulse,
  input  logic [15:0] lenth_val,
  output logic        fifo_rd_en,
  input  logic [15:0] fifo_dout,
  input  logic        fifordempty,
  output logic        udp_tx_start,
  output logic [15:0] udp_tx_len,
  input  logic        udp_tx_req,
  output logic [7:0]  udp_tx_data,
  input  logic        udp_tx_done,
  output logic        eth_tx_done,
  output logic        underrun
);

  typedef enum logic [2:0] {IDLE, PREFETCH, START, PAYLOAD, WAIT_DONE} state_t;

  state_t      state;
  logic [15:0] total;
  logic [15:0] byte_cnt;
  logic [15:0] words_left;
  logic [15:0] hold;
  logic        pf_rd;
  logic        pf_wait;
  logic        load_pend;
  logic        done_seen;
  logic        req_ok;
  logic        in_payload;
  logic        pay_rd;
  logic [15:0] word_now;
  logic [7:0]  next_byte;

`ifdef ETH_PAYLOAD_SEQ_HDR_EN
  localparam logic [15:0] HDR_BYTES = 16'd2;
  logic [15:0] seq;
  assign in_payload = (byte_cnt[15:1] != 15'd0);
`else
  localparam logic [15:0] HDR_BYTES = 16'd0;
  assign in_payload = 1'b1;
`endif

  // The header is two bytes, so payload byte parity always equals byte_cnt[0].
  assign req_ok     = (state == PAYLOAD) && udp_tx_req && (byte_cnt != total);
  assign pay_rd     = req_ok && in_payload && byte_cnt[0] && (words_left != 16'd0);
  assign fifo_rd_en = pf_rd || pay_rd;
  assign word_now   = load_pend ? fifo_dout : hold;

  always_comb begin
    next_byte = byte_cnt[0] ? word_now[7:0] : word_now[15:8];
`ifdef ETH_PAYLOAD_SEQ_HDR_EN
    if (!in_payload) next_byte = byte_cnt[0] ? seq[7:0] : seq[15:8];
`endif
  end

  always_ff @(posedge clk125M or negedge udp_gmii_rst_n) begin
    if (!udp_gmii_rst_n) begin
      state        <= IDLE;
      total        <= 16'd0;
      byte_cnt     <= 16'd0;
      words_left   <= 16'd0;
      hold         <= 16'd0;
      pf_rd        <= 1'b0;
      pf_wait      <= 1'b0;
      load_pend    <= 1'b0;
      done_seen    <= 1'b0;
      udp_tx_start <= 1'b0;
      udp_tx_len   <= 16'd0;
      udp_tx_data  <= 8'd0;
      eth_tx_done  <= 1'b0;
      underrun     <= 1'b0;
`ifdef ETH_PAYLOAD_SEQ_HDR_EN
      seq          <= HDR_SEQ_INIT;
`endif
    end else begin
      udp_tx_start <= 1'b0;
      eth_tx_done  <= 1'b0;
      pf_rd        <= 1'b0;
      load_pend    <= pay_rd;
      if (fifo_rd_en && fifordempty) underrun <= 1'b1;
      if (load_pend) hold <= fifo_dout;
      if (pay_rd) words_left <= words_left - 16'd1;
      if (req_ok) begin
        udp_tx_data <= next_byte;
        byte_cnt    <= byte_cnt + 16'd1;
      end
`ifdef ETH_PAYLOAD_SEQ_HDR_EN
      if (eth_tx_done) seq <= seq + 16'd1;
`endif
      case (state)
        IDLE: begin
          if (tx_en_pulse && (lenth_val != 16'd0)) begin
            total      <= lenth_val + HDR_BYTES;
            // The prefetch consumes one word, leaving ceil(len/2)-1 for the payload phase.
            words_left <= (lenth_val - 16'd1) >> 1;
            byte_cnt   <= 16'd0;
            done_seen  <= 1'b0;
            pf_rd      <= 1'b1;
            pf_wait    <= 1'b0;
            state      <= PREFETCH;
          end
        end
        PREFETCH: begin
          if (!pf_wait) begin
            pf_wait <= 1'b1;
          end else begin
            hold         <= fifo_dout;
            udp_tx_start <= 1'b1;
            udp_tx_len   <= total;
            state        <= START;
          end
        end
        START: state <= PAYLOAD;
        PAYLOAD: begin
          if (udp_tx_done) done_seen <= 1'b1;
          if (req_ok && (byte_cnt == total - 16'd1)) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (udp_tx_done || done_seen) begin
            eth_tx_done <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_payload_reader.sv
// Scoreboard bench for eth_payload_reader: stimulus queues expected bytes/lengths/done info,
// a monitor pops and compares whenever the DUT presents a byte, start or done.
`timescale 1ns/1ps
module tb_eth_payload_reader;

`ifdef ETH_PAYLOAD_SEQ_HDR_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif

  logic        clk125M = 1'b0;
  logic        udp_gmii_rst_n = 1'b0;
  logic        tx_en_pulse = 1'b0;
  logic [15:0] lenth_val = 16'd0;
  logic        fifo_rd_en;
  logic [15:0] fifo_dout = 16'd0;
  logic        fifordempty;
  logic        udp_tx_start;
  logic [15:0] udp_tx_len;
  logic        udp_tx_req = 1'b0;
  logic [7:0]  udp_tx_data;
  logic        udp_tx_done = 1'b0;
  logic        eth_tx_done;
  logic        underrun;

  eth_payload_reader #(.HDR_SEQ_INIT(16'd0)) dut (
    .clk125M        (clk125M),
    .udp_gmii_rst_n (udp_gmii_rst_n),
    .tx_en_pulse    (tx_en_pulse),
    .lenth_val      (lenth_val),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_dout      (fifo_dout),
    .fifordempty    (fifordempty),
    .udp_tx_start   (udp_tx_start),
    .udp_tx_len     (udp_tx_len),
    .udp_tx_req     (udp_tx_req),
    .udp_tx_data    (udp_tx_data),
    .udp_tx_done    (udp_tx_done),
    .eth_tx_done    (eth_tx_done),
    .underrun       (underrun)
  );

  always #4 clk125M = ~clk125M;

  // Standard FIFO model: dout updates the cycle after a strobe and holds when read empty.
  logic [15:0] fifo_mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        fifo_flush = 1'b0;
  assign fifordempty = (rd_ptr == wr_ptr);

  always @(posedge clk125M) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (fifo_rd_en && !fifordempty) begin
      fifo_dout <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  typedef struct packed {
    logic [15:0] reads;
    logic        und;
  } done_t;

  logic [7:0]  exp_bytes [$];
  logic [15:0] exp_len [$];
  done_t       exp_done [$];
  logic        exp_und = 1'b0;
  logic [15:0] exp_seq = 16'd0;

  int total_cnt = 0;
  int bad_cnt = 0;
  int rd_cnt = 0;
  int rd_total = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  logic req_seen = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk125M) req_seen <= udp_tx_req;

  // Monitor: pops the scoreboard whenever the DUT presents a byte, a start or a done.
  always @(negedge clk125M) begin
    logic [7:0]  b;
    logic [15:0] l;
    done_t       d;
    if (!udp_gmii_rst_n) begin
      exp_bytes.delete();
      exp_len.delete();
      exp_done.delete();
      rd_cnt = 0;
    end else begin
      if (fifo_rd_en) begin
        rd_cnt++;
        rd_total++;
      end
      if (req_seen) begin
        checkOutput("byte_pending", 32'(exp_bytes.size() != 0), 32'd1);
        if (exp_bytes.size() != 0) begin
          b = exp_bytes.pop_front();
          checkOutput("tx_data", 32'(udp_tx_data), 32'(b));
        end
      end
      if (udp_tx_start) begin
        start_cnt++;
        checkOutput("start_pending", 32'(exp_len.size() != 0), 32'd1);
        if (exp_len.size() != 0) begin
          l = exp_len.pop_front();
          checkOutput("tx_len", 32'(udp_tx_len), 32'(l));
        end
      end
      if (eth_tx_done) begin
        done_cnt++;
        checkOutput("done_pending", 32'(exp_done.size() != 0), 32'd1);
        if (exp_done.size() != 0) begin
          d = exp_done.pop_front();
          checkOutput("fifo_reads", 32'(rd_cnt), 32'(d.reads));
          checkOutput("underrun_at_done", 32'(underrun), 32'(d.und));
        end
        rd_cnt = 0;
      end
    end
  end

  task automatic loadWord(input logic [15:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic expectByte(input logic [7:0] b);
    exp_bytes.push_back(b);
  endtask

  task automatic beginDgram(input logic [15:0] len, input int reads, input bit und_now);
    done_t d;
    exp_len.push_back(len + 16'(HDR));
    if (und_now) exp_und = 1'b1;
    d.reads = 16'(reads);
    d.und   = exp_und;
    exp_done.push_back(d);
`ifdef ETH_PAYLOAD_SEQ_HDR_EN
    expectByte(exp_seq[15:8]);
    expectByte(exp_seq[7:0]);
    exp_seq = exp_seq + 16'd1;
`endif
  endtask

  task automatic waitStart();
    int n;
    n = 0;
    while (udp_tx_start !== 1'b1 && n < 20) begin
      @(posedge clk125M); #1;
      n++;
    end
    checkOutput("start_seen", 32'(udp_tx_start === 1'b1), 32'd1);
  endtask

  // Runs one full datagram; entered and left #1 after a rising edge.
  task automatic applyStimulus(input logic [15:0] len, input int gap_max, input bit done_last,
                               input bit poke);
    int total;
    total = int'(len) + HDR;
    tx_en_pulse = 1'b1;
    lenth_val   = len;
    @(posedge clk125M); #1;
    tx_en_pulse = 1'b0;
    waitStart();
    @(posedge clk125M); #1;
    for (int i = 0; i < total; i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        @(posedge clk125M); #1;
      end
      udp_tx_req = 1'b1;
      if (done_last && i == total - 1) udp_tx_done = 1'b1;
      if (poke && i == 1) begin
        tx_en_pulse = 1'b1;
        lenth_val   = 16'd4;
      end
      @(posedge clk125M); #1;
      udp_tx_req  = 1'b0;
      udp_tx_done = 1'b0;
      tx_en_pulse = 1'b0;
    end
    if (done_last) begin
      checkOutput("eth_done_early", 32'(eth_tx_done), 32'd0);
      @(posedge clk125M); #1;
    end else begin
      repeat (2) begin
        @(posedge clk125M); #1;
      end
      udp_tx_done = 1'b1;
      @(posedge clk125M); #1;
      udp_tx_done = 1'b0;
    end
    checkOutput("eth_done", 32'(eth_tx_done), 32'd1);
    @(posedge clk125M); #1;
    checkOutput("eth_done_width", 32'(eth_tx_done), 32'd0);
    @(posedge clk125M); #1;
    checkOutput("bytes_left", 32'(exp_bytes.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int snap_rd;
    int snap_start;
    int snap_done;

    repeat (3) @(posedge clk125M);
    #1;
    checkOutput("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    checkOutput("rst_tx_start", 32'(udp_tx_start), 32'd0);
    checkOutput("rst_tx_len", 32'(udp_tx_len), 32'd0);
    checkOutput("rst_tx_data", 32'(udp_tx_data), 32'd0);
    checkOutput("rst_eth_done", 32'(eth_tx_done), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    udp_gmii_rst_n = 1'b1;
    @(posedge clk125M); #1;

    $display("[TB] len 4, back-to-back requests, stray tx_en during payload");
    loadWord(16'hA1B2);
    loadWord(16'hC3D4);
    beginDgram(16'd4, 2, 1'b0);
    expectByte(8'hA1); expectByte(8'hB2); expectByte(8'hC3); expectByte(8'hD4);
    applyStimulus(16'd4, 0, 1'b0, 1'b1);

    $display("[TB] len 3, done arrives with last request");
    loadWord(16'h1122);
    loadWord(16'h3344);
    beginDgram(16'd3, 2, 1'b0);
    expectByte(8'h11); expectByte(8'h22); expectByte(8'h33);
    applyStimulus(16'd3, 0, 1'b1, 1'b0);
    checkOutput("odd_len_fifo_drained", 32'(fifordempty), 32'd1);

    $display("[TB] zero length request");
    snap_start = start_cnt;
    snap_rd    = rd_total;
    tx_en_pulse = 1'b1;
    lenth_val   = 16'd0;
    @(posedge clk125M); #1;
    tx_en_pulse = 1'b0;
    repeat (10) @(posedge clk125M);
    #1;
    checkOutput("zero_len_no_start", 32'(start_cnt), 32'(snap_start));
    checkOutput("zero_len_no_read", 32'(rd_total), 32'(snap_rd));

    $display("[TB] len 1472, gapped requests");
    for (int i = 0; i < 736; i++) loadWord({8'(i), 8'(i) ^ 8'hFF});
    beginDgram(16'd1472, 736, 1'b0);
    for (int i = 0; i < 736; i++) begin
      expectByte(8'(i));
      expectByte(8'(i) ^ 8'hFF);
    end
    applyStimulus(16'd1472, 3, 1'b0, 1'b0);
    checkOutput("long_no_underrun", 32'(underrun), 32'd0);

    $display("[TB] len 1");
    loadWord(16'hBEEF);
    beginDgram(16'd1, 1, 1'b0);
    expectByte(8'hBE);
    applyStimulus(16'd1, 1, 1'b0, 1'b0);

    $display("[TB] underrun: one word for len 4");
    loadWord(16'h5566);
    beginDgram(16'd4, 2, 1'b1);
    expectByte(8'h55); expectByte(8'h66); expectByte(8'h55); expectByte(8'h66);
    applyStimulus(16'd4, 0, 1'b0, 1'b0);
    checkOutput("underrun_sticky", 32'(underrun), 32'd1);

    $display("[TB] reset mid-payload");
    loadWord(16'h7788);
    loadWord(16'h99AA);
    beginDgram(16'd4, 2, 1'b0);
    expectByte(8'h77); expectByte(8'h88); expectByte(8'h99); expectByte(8'hAA);
    tx_en_pulse = 1'b1;
    lenth_val   = 16'd4;
    @(posedge clk125M); #1;
    tx_en_pulse = 1'b0;
    waitStart();
    @(posedge clk125M); #1;
    udp_tx_req = 1'b1;
    repeat (2) @(posedge clk125M);
    #1;
    udp_tx_req     = 1'b0;
    udp_gmii_rst_n = 1'b0;
    #1;
    checkOutput("abort_tx_data", 32'(udp_tx_data), 32'd0);
    checkOutput("abort_tx_len", 32'(udp_tx_len), 32'd0);
    checkOutput("abort_underrun", 32'(underrun), 32'd0);
    checkOutput("abort_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    exp_und    = 1'b0;
    exp_seq    = 16'd0;
    fifo_flush = 1'b1;
    @(posedge clk125M); #1;
    fifo_flush = 1'b0;
    snap_rd   = rd_total;
    snap_done = done_cnt;
    udp_gmii_rst_n = 1'b1;
    udp_tx_done = 1'b1;
    @(posedge clk125M); #1;
    udp_tx_done = 1'b0;
    repeat (10) @(posedge clk125M);
    #1;
    checkOutput("abort_no_reads", 32'(rd_total), 32'(snap_rd));
    checkOutput("abort_no_done", 32'(done_cnt), 32'(snap_done));

    $display("[TB] two len 2 datagrams after reset");
    loadWord(16'h0F1E);
    beginDgram(16'd2, 1, 1'b0);
    expectByte(8'h0F); expectByte(8'h1E);
    applyStimulus(16'd2, 1, 1'b0, 1'b0);
    loadWord(16'h2D3C);
    beginDgram(16'd2, 1, 1'b0);
    expectByte(8'h2D); expectByte(8'h3C);
    applyStimulus(16'd2, 0, 1'b0, 1'b0);

    repeat (3) @(posedge clk125M);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/eth_payload_reader.md
ETH_PAYLOAD_READER -- requirements
Module: eth_payload_reader

Interface
REQ-001 SHALL have parameters: HDR_SEQ_INIT, 16'd0, initial sequence number (used only when the Configuration feature is enabled).
REQ-002 clk125M  in  1  125 MHz system clock; all logic on rising edge.
REQ-003 udp_gmii_rst_n  in  1  asynchronous, active-low reset.
REQ-004 tx_en_pulse  in  1  one-cycle request to send one datagram.
REQ-005 lenth_val  in  16  payload length in bytes, sampled on tx_en_pulse.
REQ-006 fifo_rd_en  out  1  sample-FIFO read strobe; standard FIFO, fifo_dout valid 1 cycle after strobe.
REQ-007 fifo_dout  in  16  sample word; high byte sent first.
REQ-008 fifordempty  in  1  sample-FIFO empty flag.
REQ-009 udp_tx_start  out  1  one-cycle start pulse to UDP/IP core.
REQ-010 udp_tx_len  out  16  datagram payload byte count to UDP/IP core.
REQ-011 udp_tx_req  in  1  byte request from UDP/IP core; byte needed on udp_tx_data the following cycle.
REQ-012 udp_tx_data  out  8  payload byte, registered.
REQ-013 udp_tx_done  in  1  one-cycle completion pulse from UDP/IP core.
REQ-014 eth_tx_done  out  1  one-cycle completion pulse to the send controller.
REQ-015 underrun  out  1  sticky flag: FIFO read attempted while fifordempty high.

Function
REQ-016 SHALL implement states IDLE, PREFETCH, START, PAYLOAD, WAIT_DONE.
- IDLE: on tx_en_pulse with lenth_val != 0, latch len = lenth_val, words = ceil(len/2), byte counter = 0, go PREFETCH; tx_en_pulse with lenth_val == 0 ignored.
- PREFETCH: assert fifo_rd_en one cycle; next cycle load hold register from fifo_dout, go START.
- START: assert udp_tx_start one cycle with udp_tx_len = len (held stable until WAIT_DONE exit); go PAYLOAD.
- PAYLOAD: per udp_tx_req, next cycle drive hold[15:8] (even byte index) or hold[7:0] (odd index); byte counter increments per req.
- On odd-index req with remaining words > 0: assert fifo_rd_en same cycle; load hold the next cycle.
- After len-th req: go WAIT_DONE.
- WAIT_DONE: on udp_tx_done pulse eth_tx_done one cycle later, return IDLE.
REQ-017 Total fifo_rd_en strobes per datagram SHALL equal ceil(len/2); odd len: final low byte discarded, never sent.
REQ-018 tx_en_pulse outside IDLE SHALL be ignored.
REQ-019 udp_tx_req outside PAYLOAD, or beyond len requests, SHALL be ignored; udp_tx_data holds last value.
REQ-020 Read with fifordempty high SHALL still strobe, set underrun, and send hold contents as loaded; no stall.
REQ-021 udp_tx_done arriving same cycle as last req SHALL be captured, eth_tx_done pulses after the last byte cycle.
REQ-022 Byte counter and length arithmetic SHALL be 16-bit unsigned; no wrap for len <= 16'hFFFE.

Reset
REQ-023 On reset: state IDLE; fifo_rd_en, udp_tx_start, eth_tx_done, underrun = 0; udp_tx_len, udp_tx_data, hold, counters = 0; sequence = HDR_SEQ_INIT.
REQ-024 Reset mid-datagram SHALL abort immediately with no further FIFO reads or done pulse; underrun cleared only by reset.

Configuration
REQ-025 Macro ETH_PAYLOAD_SEQ_HDR_EN defined: each datagram prefixed with 2-byte sequence number (high byte first), udp_tx_len = len + 2, sequence increments by 1 (wrap 16'hFFFF->0) on eth_tx_done; FIFO reads unchanged.
REQ-026 Macro undefined: no header, udp_tx_len = len, no sequence register.

Verification
REQ-027 lenth_val=4, FIFO 16'hA1B2,16'hC3D4, req every cycle -> bytes A1,B2,C3,D4; 2 FIFO reads; udp_tx_len=4; eth_tx_done 1 cycle after udp_tx_done.
REQ-028 lenth_val=3, FIFO 16'h1122,16'h3344 -> bytes 11,22,33; 2 reads; byte 44 never driven.
REQ-029 lenth_val=1472, req gapped randomly 0-3 cycles -> 736 reads, 1472 bytes in FIFO order, no underrun.
REQ-030 FIFO holds 1 word, lenth_val=4 -> underrun=1 on second read, 4 bytes still sent, eth_tx_done pulses.
REQ-031 tx_en_pulse during PAYLOAD and lenth_val=0 in IDLE -> ignored, no udp_tx_start.
REQ-032 ETH_PAYLOAD_SEQ_HDR_EN defined, two datagrams lenth_val=2 -> udp_tx_len=4, headers 00,00 then 00,01; reset mid-payload -> outputs zero, no eth_tx_done.
